// File: rtl/ctrl_pkg.sv
// Shared constants, state and instruction-class types for the multicycle MIPS controller.
package ctrl_pkg;

  localparam int unsigned OP_RTYPE = 'h00;
  localparam int unsigned OP_J     = 'h02;
  localparam int unsigned OP_JAL   = 'h03;
  localparam int unsigned OP_BEQ   = 'h04;
  localparam int unsigned OP_BNE   = 'h05;
  localparam int unsigned OP_ADDI  = 'h08;
  localparam int unsigned OP_LW    = 'h23;
  localparam int unsigned OP_SW    = 'h2B;
  localparam int unsigned FUNCT_JR = 'h08;

  localparam int unsigned ALUOP_ADD   = 0;
  localparam int unsigned ALUOP_SUB   = 1;
  localparam int unsigned ALUOP_RTYPE = 4;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALUOUT = 2'd0;
  localparam logic [1:0] M2R_MDR    = 2'd1;
  localparam logic [1:0] M2R_PC     = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
    S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_ILLEGAL
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE, CLS_JR, CLS_MEM, CLS_ADDI, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } iclass_e;

endpackage

// File: rtl/ctrl_opcode_class.sv
// Combinational opcode/funct classifier feeding the DECODE transition of multicycle_control.
module ctrl_opcode_class
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int HAS_BNE  = 1
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  output iclass_e             iclass
);

  always_comb begin
    iclass = CLS_ILLEGAL;
    if (opcode == OPCODE_W'(OP_RTYPE)) begin
      iclass = (funct == FUNCT_W'(FUNCT_JR)) ? CLS_JR : CLS_RTYPE;
    end else if (opcode == OPCODE_W'(OP_LW) || opcode == OPCODE_W'(OP_SW)) begin
      iclass = CLS_MEM;
    end else if (opcode == OPCODE_W'(OP_ADDI)) begin
      iclass = CLS_ADDI;
    end else if (opcode == OPCODE_W'(OP_BEQ) ||
                 (HAS_BNE != 0 && opcode == OPCODE_W'(OP_BNE))) begin
      iclass = CLS_BRANCH;
    end else if (opcode == OPCODE_W'(OP_J) || opcode == OPCODE_W'(OP_JAL)) begin
      iclass = CLS_JUMP;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM with unified-memory ready/request handshake.
// Optional CTRL_ILLEGAL_TRAP_EN makes ILLEGAL a sticky halt raising exc_illegal.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNCT_W  = 6,
  parameter int ALUOP_W  = 3,
  parameter int HAS_BNE  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                branch_ne,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic [1:0]          reg_dst,
  output logic [1:0]          mem_to_reg,
  output logic                reg_write,
  output logic                instr_done,
  output logic                exc_illegal
);

  state_e  state_q, state_d;
  iclass_e iclass;
  // Sub-class flags captured in DECODE so later opcode changes cannot steer the sequence.
  logic    is_sw_q, is_sw_d, is_bne_q, is_bne_d, is_jal_q, is_jal_d;

  ctrl_opcode_class #(
    .OPCODE_W (OPCODE_W),
    .FUNCT_W  (FUNCT_W),
    .HAS_BNE  (HAS_BNE)
  ) u_class (
    .opcode (opcode),
    .funct  (funct),
    .iclass (iclass)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      is_sw_q  <= 1'b0;
      is_bne_q <= 1'b0;
      is_jal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_sw_q  <= is_sw_d;
      is_bne_q <= is_bne_d;
      is_jal_q <= is_jal_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    is_sw_d       = is_sw_q;
    is_bne_d      = is_bne_q;
    is_jal_d      = is_jal_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_op        = ALUOP_W'(ALUOP_ADD);
    reg_dst       = REGDST_RT;
    mem_to_reg    = M2R_ALUOUT;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    exc_illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        is_sw_d   = (opcode == OPCODE_W'(OP_SW));
        is_bne_d  = (opcode == OPCODE_W'(OP_BNE));
        is_jal_d  = (opcode == OPCODE_W'(OP_JAL));
        case (iclass)
          CLS_RTYPE:  state_d = S_EXEC_R;
          CLS_JR:     state_d = S_JR;
          CLS_MEM:    state_d = S_MEM_ADDR;
          CLS_ADDI:   state_d = S_EXEC_I;
          CLS_BRANCH: state_d = S_BRANCH;
          CLS_JUMP:   state_d = S_JUMP;
          default:    state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALUOP_W'(ALUOP_RTYPE);
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst    = REGDST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = is_sw_q ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_to_reg = M2R_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = SRCB_RT;
        alu_op        = ALUOP_W'(ALUOP_SUB);
        pc_src        = PCSRC_ALUOUT;
        pc_write_cond = 1'b1;
        branch_ne     = is_bne_q;
        instr_done    = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        if (is_jal_q) begin
          reg_write  = 1'b1;
          reg_dst    = REGDST_RA;
          mem_to_reg = M2R_PC;
        end
        state_d = S_FETCH;
      end
      S_JR: begin
        pc_src     = PCSRC_RS;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        exc_illegal = 1'b1;
        state_d     = S_ILLEGAL;
`else
        instr_done = 1'b1;
        state_d    = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every strobe combinationally, including in the reset cycle itself.
    if (rst) begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      branch_ne     = 1'b0;
      pc_src        = '0;
      alu_src_a     = 1'b0;
      alu_src_b     = '0;
      alu_op        = '0;
      reg_dst       = '0;
      mem_to_reg    = '0;
      reg_write     = 1'b0;
      instr_done    = 1'b0;
      exc_illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; honours CTRL_ILLEGAL_TRAP_EN when defined.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;

  logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic       alu_src_a, reg_write, instr_done, exc_illegal;
  logic [2:0] alu_op;

  logic       n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_write_cond, n_branch_ne;
  logic [1:0] n_pc_src, n_alu_src_b, n_reg_dst, n_mem_to_reg;
  logic       n_alu_src_a, n_reg_write, n_instr_done, n_exc_illegal;
  logic [2:0] n_alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(3), .HAS_BNE(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .instr_done(instr_done), .exc_illegal(exc_illegal)
  );

  multicycle_control #(.OPCODE_W(6), .FUNCT_W(6), .ALUOP_W(3), .HAS_BNE(0)) dut_nb (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord), .ir_write(n_ir_write),
    .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .branch_ne(n_branch_ne),
    .pc_src(n_pc_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .alu_op(n_alu_op),
    .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
    .instr_done(n_instr_done), .exc_illegal(n_exc_illegal)
  );

  // Field order: req we iord irw pcw pcwc bne pcsrc asa asb aluop rdst m2r rw done exc
  wire [21:0] obs = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, branch_ne,
                     pc_src, alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
                     reg_write, instr_done, exc_illegal};
  wire [21:0] obs_nb = {n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_write_cond,
                        n_branch_ne, n_pc_src, n_alu_src_a, n_alu_src_b, n_alu_op, n_reg_dst,
                        n_mem_to_reg, n_reg_write, n_instr_done, n_exc_illegal};

  logic [21:0] V_ZERO, V_FETCH_WAIT, V_FETCH_GO, V_DECODE, V_EXEC_R, V_WB_R, V_EXEC_I, V_WB_I;
  logic [21:0] V_MEM_RD, V_WB_MEM, V_MEM_WR_WAIT, V_MEM_WR_GO, V_BEQ, V_BNE;
  logic [21:0] V_J, V_JAL, V_JR, V_NOP, V_TRAP;

  function automatic logic [21:0] v(input logic req, we, io, irw, pcw, pcwc, bne,
                                    input logic [1:0] pcs, input logic asa,
                                    input logic [1:0] asb, input logic [2:0] aop,
                                    input logic [1:0] rd, m2r, input logic rw, dn, ex);
    return {req, we, io, irw, pcw, pcwc, bne, pcs, asa, asb, aop, rd, m2r, rw, dn, ex};
  endfunction

  task automatic test_reset_lw();
    logic [21:0] exp [5];
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 3; i++) begin
      #3;
      n_cmp++;
      if (obs !== V_ZERO) begin
        n_bad++;
        $display("FAIL reset_outputs cyc%0d: got %h want %h", i, obs, V_ZERO);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    exp = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_MEM_RD, V_WB_MEM};
    for (int i = 0; i < 5; i++) begin
      if (i == 2) opcode = 6'h2B;
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL lw cyc%0d: got %h want %h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype_wait();
    logic [21:0] exp [6];
    logic        rdy [6];
    exp = '{V_FETCH_WAIT, V_FETCH_WAIT, V_FETCH_GO, V_DECODE, V_EXEC_R, V_WB_R};
    rdy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    opcode = 6'h3F; funct = 6'h20;
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      if (i == 2) opcode = 6'h00;
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL rtype_wait cyc%0d: got %h want %h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_addi();
    logic [21:0] exp [4];
    exp = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_WB_I};
    opcode = 6'h08; funct = 6'h08; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL addi cyc%0d: got %h want %h", i + 1, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [21:0] exp [6];
    logic [21:0] exp_nb [3];
    logic [5:0]  ops [2];
    exp = '{V_FETCH_GO, V_DECODE, V_BEQ, V_FETCH_GO, V_DECODE, V_BNE};
`ifdef CTRL_ILLEGAL_TRAP_EN
    exp_nb = '{V_FETCH_GO, V_DECODE, V_TRAP};
`else
    exp_nb = '{V_FETCH_GO, V_DECODE, V_NOP};
`endif
    ops = '{6'h04, 6'h05};
    funct = 6'h00;
    for (int i = 0; i < 6; i++) begin
      opcode = ops[i / 3];
      mem_ready = (i % 3 == 0);
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL branch cyc%0d op%h: got %h want %h", i % 3 + 1, opcode, obs, exp[i]);
      end
      if (i >= 3) begin
        n_cmp++;
        if (obs_nb !== exp_nb[i - 3]) begin
          n_bad++;
          $display("FAIL bne_disabled cyc%0d: got %h want %h", i - 2, obs_nb, exp_nb[i - 3]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jump();
    logic [21:0] exp [9];
    logic [5:0]  ops [3];
    logic [5:0]  fns [3];
    exp = '{V_FETCH_GO, V_DECODE, V_J, V_FETCH_GO, V_DECODE, V_JAL,
            V_FETCH_GO, V_DECODE, V_JR};
    ops = '{6'h02, 6'h03, 6'h00};
    fns = '{6'h08, 6'h00, 6'h08};
    mem_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      opcode = ops[i / 3];
      funct  = fns[i / 3];
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL jump cyc%0d op%h: got %h want %h", i % 3 + 1, opcode, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_reset();
    logic [21:0] exp [13];
    logic        rdy [13];
    logic        rs  [13];
    // sw with one MEM_WR wait, then sw reset mid-wait, then a clean sw after release.
    exp = '{V_FETCH_GO, V_DECODE, V_EXEC_I, V_MEM_WR_WAIT, V_MEM_WR_GO,
            V_FETCH_GO, V_DECODE, V_EXEC_I, V_MEM_WR_WAIT, V_ZERO,
            V_FETCH_GO, V_DECODE, V_EXEC_I};
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    opcode = 6'h2B; funct = 6'h00;
    for (int i = 0; i < 13; i++) begin
      mem_ready = rdy[i];
      rst = rs[i];
      #3;
      n_cmp++;
      if (obs !== exp[i]) begin
        n_bad++;
        $display("FAIL sw_reset step%0d: got %h want %h", i, obs, exp[i]);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    mem_ready = 1'b1;
    #3;
    n_cmp++;
    if (obs !== V_MEM_WR_GO) begin
      n_bad++;
      $display("FAIL sw_after_reset: got %h want %h", obs, V_MEM_WR_GO);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1; opcode = 6'h3F; funct = 6'h00;
    #3;
    n_cmp++;
    if (obs !== V_FETCH_GO) begin
      n_bad++;
      $display("FAIL illegal_fetch: got %h want %h", obs, V_FETCH_GO);
    end
    @(posedge clk); #1;
    #3;
    n_cmp++;
    if (obs !== V_DECODE) begin
      n_bad++;
      $display("FAIL illegal_decode: got %h want %h", obs, V_DECODE);
    end
    @(posedge clk); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode = (i == 5) ? 6'h00 : 6'h3F;
      #3;
      n_cmp++;
      if (obs !== V_TRAP) begin
        n_bad++;
        $display("FAIL illegal_trap cyc%0d: got %h want %h", i, obs, V_TRAP);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    #3;
    n_cmp++;
    if (obs !== V_FETCH_GO) begin
      n_bad++;
      $display("FAIL trap_release: got %h want %h", obs, V_FETCH_GO);
    end
    @(posedge clk); #1;
`else
    #3;
    n_cmp++;
    if (obs !== V_NOP) begin
      n_bad++;
      $display("FAIL illegal_nop: got %h want %h", obs, V_NOP);
    end
    @(posedge clk); #1;
    #3;
    n_cmp++;
    if (obs !== V_FETCH_GO) begin
      n_bad++;
      $display("FAIL illegal_next_fetch: got %h want %h", obs, V_FETCH_GO);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0;
    V_ZERO        = '0;
    V_FETCH_WAIT  = v(1,0,0,0,0,0,0, 2'd0, 0, 2'd1, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_FETCH_GO    = v(1,0,0,1,1,0,0, 2'd0, 0, 2'd1, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_DECODE      = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd3, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_EXEC_R      = v(0,0,0,0,0,0,0, 2'd0, 1, 2'd0, 3'd4, 2'd0, 2'd0, 0,0,0);
    V_WB_R        = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd1, 2'd0, 1,1,0);
    V_EXEC_I      = v(0,0,0,0,0,0,0, 2'd0, 1, 2'd2, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_WB_I        = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 1,1,0);
    V_MEM_RD      = v(1,0,1,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_WB_MEM      = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd1, 1,1,0);
    V_MEM_WR_WAIT = v(1,1,1,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,0,0);
    V_MEM_WR_GO   = v(1,1,1,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,1,0);
    V_BEQ         = v(0,0,0,0,0,1,0, 2'd1, 1, 2'd0, 3'd1, 2'd0, 2'd0, 0,1,0);
    V_BNE         = v(0,0,0,0,0,1,1, 2'd1, 1, 2'd0, 3'd1, 2'd0, 2'd0, 0,1,0);
    V_J           = v(0,0,0,0,1,0,0, 2'd2, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,1,0);
    V_JAL         = v(0,0,0,0,1,0,0, 2'd2, 0, 2'd0, 3'd0, 2'd2, 2'd2, 1,1,0);
    V_JR          = v(0,0,0,0,1,0,0, 2'd3, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,1,0);
    V_NOP         = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,1,0);
    V_TRAP        = v(0,0,0,0,0,0,0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0,0,1);
    @(posedge clk); #1;
    test_reset_lw();
    test_rtype_wait();
    test_addi();
    test_branch();
    test_jump();
    test_sw_reset();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
